// File: rtl/player_state_engine.sv
// Per-player state: positions, lives, invincibility timers and corner-walkability flags.
// A probe sweep FSM queries the tile/explosion lookup for each player's four sprite corners.
module player_state_engine #(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 9,
    parameter int SPRITE_SIZE = 16,
    parameter int SPEED       = 2,
    parameter int MIN_X       = 72,
    parameter int MAX_X       = 232,
    parameter int MIN_Y       = 32,
    parameter int MAX_Y       = 192,
    parameter int MAX_LIVES   = 3,
    parameter int LIVES_W     = 2,
    parameter int INV_TICKS   = 100,
    parameter int TICK_W      = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             player_reset,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   start_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   start_y,
    input  logic [NUM_PLAYERS-1:0]           xmov,
    input  logic [NUM_PLAYERS-1:0]           xdir,
    input  logic [NUM_PLAYERS-1:0]           ymov,
    input  logic [NUM_PLAYERS-1:0]           ydir,
    input  logic                             refresh,
    input  logic                             tick_en,
    input  logic                             sweep_start,
    output logic                             probe_req,
    output logic [COORD_W-1:0]               probe_x,
    output logic [COORD_W-1:0]               probe_y,
    input  logic                             probe_ack,
    input  logic                             probe_empty,
    input  logic                             probe_explosion,
    output logic                             sweep_done,
    output logic [NUM_PLAYERS*COORD_W-1:0]   pos_x,
    output logic [NUM_PLAYERS*COORD_W-1:0]   pos_y,
    output logic [NUM_PLAYERS*LIVES_W-1:0]   lives,
    output logic [NUM_PLAYERS-1:0]           invincible,
    output logic [NUM_PLAYERS-1:0]           dead,
    output logic [NUM_PLAYERS-1:0]           hit_pulse
);

    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [COORD_W-1:0] OFFS    = COORD_W'(SPRITE_SIZE - 1);
    localparam logic [COORD_W:0]   SPEED_C = (COORD_W+1)'(SPEED);
    localparam logic [COORD_W:0]   MIN_X_C = (COORD_W+1)'(MIN_X);
    localparam logic [COORD_W:0]   MAX_X_C = (COORD_W+1)'(MAX_X);
    localparam logic [COORD_W:0]   MIN_Y_C = (COORD_W+1)'(MIN_Y);
    localparam logic [COORD_W:0]   MAX_Y_C = (COORD_W+1)'(MAX_Y);

    typedef enum logic [1:0] {IDLE, REQ, APPLY, DONE} state_t;

    state_t               state;
    logic [PW-1:0]        p_idx;
    logic [1:0]           c_idx;
    logic [NUM_PLAYERS-1:0] hit_acc;
    logic                 refresh_pending;
    logic [COORD_W-1:0]   pos_x_r [NUM_PLAYERS];
    logic [COORD_W-1:0]   pos_y_r [NUM_PLAYERS];
    logic [LIVES_W-1:0]   lives_r [NUM_PLAYERS];
    logic [TICK_W-1:0]    timer_r [NUM_PLAYERS];
    logic [3:0]           empty_r [NUM_PLAYERS];

    logic                 last_probe;
    logic [PW-1:0]        next_p;
    logic [1:0]           next_c;
    logic [COORD_W-1:0]   next_probe_x;
    logic [COORD_W-1:0]   next_probe_y;
    logic [NUM_PLAYERS-1:0] hit_now;

    // Clamped steps are computed one bit wider so the sum/difference cannot wrap.
    function automatic logic [COORD_W-1:0] step_up(input logic [COORD_W-1:0] pos,
                                                   input logic [COORD_W:0] max_c);
        logic [COORD_W:0] sum;
        sum = {1'b0, pos} + SPEED_C;
        return (sum > max_c) ? max_c[COORD_W-1:0] : sum[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] step_down(input logic [COORD_W-1:0] pos,
                                                     input logic [COORD_W:0] min_c);
        logic [COORD_W:0] diff;
        diff = {1'b0, pos} - SPEED_C;
        return ({1'b0, pos} < (min_c + SPEED_C)) ? min_c[COORD_W-1:0] : diff[COORD_W-1:0];
    endfunction

    always_comb begin
        last_probe   = (p_idx == PW'(NUM_PLAYERS - 1)) && (c_idx == 2'd3);
        next_c       = c_idx + 2'd1;
        next_p       = (c_idx == 2'd3) ? p_idx + PW'(1) : p_idx;
        next_probe_x = pos_x_r[next_p] + (next_c[0] ? OFFS : '0);
        next_probe_y = pos_y_r[next_p] + (next_c[1] ? OFFS : '0);
        hit_now      = '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            hit_now[i] = hit_acc[i] && (timer_r[i] == '0) && (lives_r[i] != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            p_idx           <= '0;
            c_idx           <= '0;
            hit_acc         <= '0;
            refresh_pending <= 1'b0;
            probe_req       <= 1'b0;
            probe_x         <= '0;
            probe_y         <= '0;
            sweep_done      <= 1'b0;
            hit_pulse       <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_x_r[i] <= start_x[i*COORD_W +: COORD_W];
                pos_y_r[i] <= start_y[i*COORD_W +: COORD_W];
                lives_r[i] <= LIVES_W'(MAX_LIVES);
                timer_r[i] <= '0;
                empty_r[i] <= '0;
            end
        end else if (player_reset) begin
            state           <= IDLE;
            p_idx           <= '0;
            c_idx           <= '0;
            hit_acc         <= '0;
            refresh_pending <= 1'b0;
            probe_req       <= 1'b0;
            probe_x         <= '0;
            probe_y         <= '0;
            sweep_done      <= 1'b0;
            hit_pulse       <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_x_r[i] <= start_x[i*COORD_W +: COORD_W];
                pos_y_r[i] <= start_y[i*COORD_W +: COORD_W];
                lives_r[i] <= LIVES_W'(MAX_LIVES);
                timer_r[i] <= '0;
                empty_r[i] <= '0;
            end
        end else begin
            sweep_done <= 1'b0;
            hit_pulse  <= '0;

            // A damage load in APPLY wins over a simultaneous tick.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (state == APPLY && hit_now[i])
                    timer_r[i] <= TICK_W'(INV_TICKS);
                else if (tick_en && timer_r[i] != '0)
                    timer_r[i] <= timer_r[i] - TICK_W'(1);
            end

            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        p_idx     <= '0;
                        c_idx     <= '0;
                        hit_acc   <= '0;
                        probe_req <= 1'b1;
                        probe_x   <= pos_x_r[0];
                        probe_y   <= pos_y_r[0];
                        state     <= REQ;
                    end else if (refresh_pending) begin
                        refresh_pending <= 1'b0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (lives_r[i] != '0) begin
                                if (xmov[i] && xdir[i] && empty_r[i][1] && empty_r[i][3])
                                    pos_x_r[i] <= step_up(pos_x_r[i], MAX_X_C);
                                else if (xmov[i] && !xdir[i] && empty_r[i][0] && empty_r[i][2])
                                    pos_x_r[i] <= step_down(pos_x_r[i], MIN_X_C);
                                if (ymov[i] && ydir[i] && empty_r[i][2] && empty_r[i][3])
                                    pos_y_r[i] <= step_up(pos_y_r[i], MAX_Y_C);
                                else if (ymov[i] && !ydir[i] && empty_r[i][0] && empty_r[i][1])
                                    pos_y_r[i] <= step_down(pos_y_r[i], MIN_Y_C);
                            end
                        end
                    end
                end
                REQ: begin
                    if (probe_ack) begin
                        empty_r[p_idx][c_idx] <= probe_empty;
                        hit_acc[p_idx]        <= hit_acc[p_idx] | probe_explosion;
                        if (last_probe) begin
                            probe_req <= 1'b0;
                            state     <= APPLY;
                        end else begin
                            p_idx   <= next_p;
                            c_idx   <= next_c;
                            probe_x <= next_probe_x;
                            probe_y <= next_probe_y;
                        end
                    end
                end
                APPLY: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (hit_now[i]) begin
                            lives_r[i]   <= lives_r[i] - LIVES_W'(1);
                            hit_pulse[i] <= 1'b1;
                        end
                    end
                    sweep_done <= 1'b1;
                    state      <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (refresh)
                refresh_pending <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_out
        assign pos_x[g*COORD_W +: COORD_W] = pos_x_r[g];
        assign pos_y[g*COORD_W +: COORD_W] = pos_y_r[g];
        assign lives[g*LIVES_W +: LIVES_W] = lives_r[g];
        assign invincible[g]               = (timer_r[g] != '0);
        assign dead[g]                     = (lives_r[g] == '0);
    end

endmodule

// File: tb/tb_player_state_engine.sv
// Directed bench for player_state_engine: sweeps, damage, invincibility, clamped movement, resets.
module tb_player_state_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        player_reset;
    logic [17:0] start_x, start_y;
    logic [1:0]  xmov, xdir, ymov, ydir;
    logic        refresh, tick_en, sweep_start;
    logic        probe_req;
    logic [8:0]  probe_x, probe_y;
    logic        probe_ack, probe_empty, probe_explosion;
    logic        sweep_done;
    logic [17:0] pos_x, pos_y;
    logic [3:0]  lives;
    logic [1:0]  invincible, dead, hit_pulse;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  px [8];
    logic [8:0]  py [8];
    int          done_cnt, hit_cnt, stable_err;
    logic [17:0] pos_x_apply;

    player_state_engine dut (
        .clock(clock), .reset(reset), .player_reset(player_reset),
        .start_x(start_x), .start_y(start_y),
        .xmov(xmov), .xdir(xdir), .ymov(ymov), .ydir(ydir),
        .refresh(refresh), .tick_en(tick_en), .sweep_start(sweep_start),
        .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
        .probe_ack(probe_ack), .probe_empty(probe_empty), .probe_explosion(probe_explosion),
        .sweep_done(sweep_done), .pos_x(pos_x), .pos_y(pos_y), .lives(lives),
        .invincible(invincible), .dead(dead), .hit_pulse(hit_pulse)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_move(input logic [1:0] xm, input logic [1:0] xd,
                            input logic [1:0] ym, input logic [1:0] yd);
        xmov = xm; xdir = xd; ymov = ym; ydir = yd;
    endtask

    task automatic do_refresh();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        step();
        step();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_en = 1'b1;
            step();
            tick_en = 0;
            step();
        end
    endtask

    task automatic pulse_player_reset();
        player_reset = 1'b1;
        step();
        player_reset = 1'b0;
        step();
    endtask

    // Player 0 corners answer from emp0/exp0 (bit = corner); player 1 is always clear.
    task automatic run_sweep(input logic [3:0] emp0, input logic [3:0] exp0,
                             input int delay, input bit mid_refresh);
        logic [8:0] hold_x, hold_y;
        done_cnt = 0; hit_cnt = 0; stable_err = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            for (int g = 0; g < 20 && !probe_req; g++) step();
            if (!probe_req) check("probe_req_wait", probe_req, 1);
            hold_x = probe_x;
            hold_y = probe_y;
            if (mid_refresh && n == 2) begin
                refresh = 1'b1;
                step();
                refresh = 1'b0;
            end
            for (int d = 0; d < delay; d++) begin
                step();
                if (probe_x !== hold_x || probe_y !== hold_y || probe_req !== 1'b1) stable_err++;
            end
            px[n] = probe_x;
            py[n] = probe_y;
            probe_ack       = 1'b1;
            probe_empty     = (n < 4) ? emp0[n] : 1'b1;
            probe_explosion = (n < 4) ? exp0[n] : 1'b0;
            step();
            probe_ack = 1'b0;
        end
        pos_x_apply = pos_x;
        check("probe_req_drop", probe_req, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            if (sweep_done) done_cnt++;
            if (hit_pulse[0]) hit_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; player_reset = 1'b0;
        start_x = {9'd232, 9'd72};
        start_y = {9'd112, 9'd112};
        set_move(2'b00, 2'b00, 2'b00, 2'b00);
        refresh = 0; tick_en = 0; sweep_start = 0;
        probe_ack = 0; probe_empty = 0; probe_explosion = 0;
        step(); step();
        reset = 1'b0;
        step();

        check("rst_pos_x", pos_x, {9'd232, 9'd72});
        check("rst_pos_y", pos_y, {9'd112, 9'd112});
        check("rst_lives", lives, {2'd3, 2'd3});
        check("rst_inv", invincible, 0);
        check("rst_probe_req", probe_req, 0);
        check("rst_dead", dead, 0);

        // No movement before the first sweep: empty flags are clear.
        set_move(2'b01, 2'b01, 2'b00, 2'b00);
        do_refresh();
        check("premove_x", pos_x, {9'd232, 9'd72});

        run_sweep(4'hF, 4'h0, 0, 0);
        check("c0_x", px[0], 72);  check("c0_y", py[0], 112);
        check("c1_x", px[1], 87);  check("c1_y", py[1], 112);
        check("c2_x", px[2], 72);  check("c2_y", py[2], 127);
        check("c3_x", px[3], 87);  check("c3_y", py[3], 127);
        check("p1c1_x", px[5], 247);
        check("p1c3_y", py[7], 127);
        check("clean_done", done_cnt, 1);
        check("clean_hit", hit_cnt, 0);
        check("clean_lives", lives, {2'd3, 2'd3});
        do_refresh();
        check("move_px", pos_x, {9'd232, 9'd74});

        set_move(2'b00, 2'b00, 2'b00, 2'b00);
        run_sweep(4'hF, 4'hF, 0, 0);
        check("hit_lives", lives, {2'd3, 2'd2});
        check("hit_pulse_cnt", hit_cnt, 1);
        check("hit_inv", invincible, 2'b01);
        run_sweep(4'hF, 4'hF, 0, 0);
        check("inv_lives", lives, {2'd3, 2'd2});
        check("inv_hit_cnt", hit_cnt, 0);
        do_ticks(99);
        check("inv_99", invincible, 2'b01);
        do_ticks(1);
        check("inv_100", invincible, 2'b00);

        // Clamp at MAX_X from 231.
        start_x = {9'd232, 9'd231};
        pulse_player_reset();
        check("prst_x231", pos_x, {9'd232, 9'd231});
        check("prst_lives", lives, {2'd3, 2'd3});
        run_sweep(4'hF, 4'h0, 0, 0);
        set_move(2'b01, 2'b01, 2'b00, 2'b00);
        do_refresh();
        check("clamp_max1", pos_x[8:0], 232);
        do_refresh();
        check("clamp_max2", pos_x[8:0], 232);

        // Clamp at MIN_X from 73.
        start_x = {9'd232, 9'd73};
        pulse_player_reset();
        run_sweep(4'hF, 4'h0, 0, 0);
        set_move(2'b01, 2'b00, 2'b00, 2'b00);
        do_refresh();
        check("clamp_min1", pos_x[8:0], 72);
        do_refresh();
        check("clamp_min2", pos_x[8:0], 72);

        set_move(2'b01, 2'b01, 2'b01, 2'b00);
        do_refresh();
        check("axes_x", pos_x, {9'd232, 9'd74});
        check("axes_y", pos_y, {9'd112, 9'd110});

        run_sweep(4'b1101, 4'h0, 0, 0);
        set_move(2'b01, 2'b01, 2'b01, 2'b01);
        do_refresh();
        check("blk_x", pos_x[8:0], 74);
        check("blk_y", pos_y[8:0], 112);

        set_move(2'b00, 2'b00, 2'b00, 2'b00);
        run_sweep(4'hF, 4'h0, 5, 0);
        check("hold_stable", stable_err, 0);
        check("hold_c0_x", px[0], 74);
        check("hold_c3_x", px[3], 89);
        check("hold_c3_y", py[3], 127);
        check("hold_done", done_cnt, 1);

        set_move(2'b01, 2'b01, 2'b00, 2'b00);
        run_sweep(4'hF, 4'h0, 0, 1);
        check("mid_ref_apply", pos_x_apply[8:0], 74);
        check("mid_ref_after", pos_x[8:0], 76);
        set_move(2'b00, 2'b00, 2'b00, 2'b00);

        run_sweep(4'hF, 4'hF, 0, 0);
        check("pre_prst_lives", lives, {2'd3, 2'd2});
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            probe_ack = 1'b1; probe_empty = 1'b1; probe_explosion = 1'b1;
            step();
            probe_ack = 1'b0;
        end
        player_reset = 1'b1;
        step();
        player_reset = 1'b0;
        check("prst_req", probe_req, 0);
        check("prst_lives2", lives, {2'd3, 2'd3});
        check("prst_pos", pos_x, {9'd232, 9'd73});
        check("prst_inv", invincible, 0);
        step(); step(); step();
        check("prst_no_apply", lives, {2'd3, 2'd3});
        run_sweep(4'hF, 4'h0, 0, 0);
        check("prst_resweep", done_cnt, 1);
        check("prst_c0_x", px[0], 73);

        // Drain all lives, waiting out invincibility between hits.
        run_sweep(4'hF, 4'hF, 0, 0);
        do_ticks(100);
        run_sweep(4'hF, 4'hF, 0, 0);
        check("lives_1", lives[1:0], 1);
        do_ticks(100);
        run_sweep(4'hF, 4'hF, 0, 0);
        check("lives_0", lives[1:0], 0);
        check("dead_set", dead, 2'b01);
        do_ticks(100);
        run_sweep(4'hF, 4'hF, 0, 0);
        check("lives_floor", lives[1:0], 0);
        check("dead_no_hit", hit_cnt, 0);
        set_move(2'b01, 2'b01, 2'b00, 2'b00);
        do_refresh();
        check("dead_no_move", pos_x[8:0], 73);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_state_engine.md
Name: player_state_engine

Overview:
- Parametrised per-player state block for the game datapath.
- Holds, for NUM_PLAYERS players:
  - sprite coordinates
  - lives
  - invincibility timers
  - corner-collision flags
- Runs a corner-probe sweep FSM against the tile/explosion lookup over a request/acknowledge handshake.
- Applies damage at most once per sweep.
- Applies independent X/Y movement on refresh pulses.

Parameters:
NUM_PLAYERS, 2, number of players (1..4)
COORD_W, 9, coordinate width in bits
SPRITE_SIZE, 16, sprite edge in pixels; corner offset = SPRITE_SIZE-1
SPEED, 2, pixels moved per refresh pulse
MIN_X, 72, minimum legal X
MAX_X, 232, maximum legal X
MIN_Y, 32, minimum legal Y
MAX_Y, 192, maximum legal Y
MAX_LIVES, 3, lives after reset (must fit LIVES_W)
LIVES_W, 2, lives field width
INV_TICKS, 100, invincibility length in tick_en pulses
TICK_W, 8, invincibility counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
player_reset  in  1  synchronous round restart
start_x  in  NUM_PLAYERS*COORD_W  packed start X per player (player p at [p*COORD_W +: COORD_W])
start_y  in  NUM_PLAYERS*COORD_W  packed start Y per player
xmov, xdir, ymov, ydir  in  NUM_PLAYERS each  move requests (dir 1 = increase)
refresh  in  1  one-cycle movement strobe, synchronous to clock
tick_en  in  1  one-cycle timebase strobe for invincibility
sweep_start  in  1  one-cycle pulse, begin probe sweep
probe_req  out  1  probe address valid
probe_x  out  COORD_W  probe X
probe_y  out  COORD_W  probe Y
probe_ack  in  1  lookup result valid
probe_empty  in  1  tile at probe is walkable
probe_explosion  in  1  explosion present at probe
sweep_done  out  1  one-cycle pulse, sweep finished
pos_x  out  NUM_PLAYERS*COORD_W  packed X
pos_y  out  NUM_PLAYERS*COORD_W  packed Y
lives  out  NUM_PLAYERS*LIVES_W  packed lives
invincible  out  NUM_PLAYERS  timer nonzero
dead  out  NUM_PLAYERS  lives == 0
hit_pulse  out  NUM_PLAYERS  one-cycle, life was lost

Behaviour:

Reset (reset, and player_reset identically; player_reset is synchronous and overrides all else):
- pos = start_x/start_y.
- lives = MAX_LIVES.
- Timers = 0.
- Empty flags = 0.
- FSM = IDLE.
- probe_req, sweep_done, hit_pulse = 0.
- hit accumulators = 0.
- refresh_pending = 0.

FSM states: IDLE, REQ, APPLY, DONE.
- IDLE: on sweep_start, clear player index p = 0, corner index c = 0, clear hit accumulators, go to REQ. sweep_start outside IDLE is ignored.
- REQ:
  - probe_req = 1; probe_x/probe_y are registered and stable until ack.
  - Corner addresses (S = SPRITE_SIZE-1):
    - c0 = (x, y)
    - c1 = (x+S, y)
    - c2 = (x, y+S)
    - c3 = (x+S, y+S)
  - On a cycle with probe_ack = 1:
    - empty[p][c] <= probe_empty.
    - hit_acc[p] |= probe_explosion.
    - Advance c; after c = 3, advance p and reset c to 0.
    - After the last (p, c), go to APPLY. probe_req drops in the cycle after the final ack.
  - Minimum sweep length: 4*NUM_PLAYERS acks, then +2 cycles.
- APPLY (one cycle), per player: if hit_acc & !invincible & lives != 0, then:
  - lives -= 1
  - timer <= INV_TICKS
  - hit_pulse[p] = 1 next cycle
  - All players are evaluated in parallel.
  - Multiple hits in one sweep cost one life.
- DONE: sweep_done = 1 for one cycle, then IDLE.

Invincibility timer:
- Decrements on tick_en when nonzero; saturates at 0.
- A load in APPLY takes priority over a simultaneous tick.
- invincible = timer != 0.

Movement:
- A refresh pulse sets refresh_pending.
- Movement is applied in the first IDLE cycle with refresh_pending = 1 and no sweep_start; refresh_pending then clears. A sweep_start in the same cycle wins and movement waits. Movement never happens mid-sweep.
- X and Y are evaluated independently and can both move in one update.
- Uses empty flags from the last completed sweep:
  - +X needs empty[1] & empty[3].
  - -X needs empty[0] & empty[2].
  - +Y needs empty[2] & empty[3].
  - -Y needs empty[0] & empty[1].
- Clamp:
  - +: new = min(pos+SPEED, MAX).
  - -: new = max(pos-SPEED, MIN).
  - Compute at COORD_W+1 bits so there is no wrap.
- Dead players do not move.
- Empty flags are 0 after reset, so no movement occurs before the first sweep.

dead: combinational, lives == 0. Lives never go below 0.

Test Plan:
- Reset (default params): pos_x = {232, 72}, pos_y = {112, 112} from starts, lives = 3 each, invincible = 0, probe_req = 0.
- Sweep, all acks empty=1, explosion=0 -> 8 probes.
  - Player 0 at (72, 112) probes (72,112), (87,112), (72,127), (87,127).
  - sweep_done pulses once; lives unchanged.
  - Then refresh with xmov0 = 1, xdir0 = 1 -> pos_x0 = 74.
- Sweep with explosion=1 on all four corners of player 0 -> lives0 = 3→2 (single decrement), hit_pulse0 one cycle, invincible0 = 1.
  - Immediate second identical sweep -> lives0 stays 2.
  - After 100 tick_en pulses -> invincible0 = 0.
- Clamp: player 0 at X = 231, SPEED = 2, +X allowed -> 232; a further refresh -> stays 232. At X = 73, -X -> 72.
- Independent axes: empty all 1, xmov = ymov = 1, xdir = 1, ydir = 0 in one refresh -> X +2 and Y -2 together.
  - With empty[1] = 0: X blocked, Y still moves.
- Handshake / reset:
  - Delay probe_ack 5 cycles -> probe_x/probe_y held constant.
  - refresh mid-sweep -> applied only after DONE.
  - Assert player_reset mid-sweep -> IDLE, probe_req = 0, lives = 3, positions restored.
